// File: rtl/cam_pkg.sv
// Shared types and helpers for the camera frame sampler.
// Optional build macro: CAM_SAMPLE_INVERT_EN (inverts sampled grayscale).
package cam_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    SKIP    = 2'd2
  } samp_state_t;

  localparam int unsigned GS_BITS   = 8;
  localparam int unsigned DROP_BITS = 16;

  // Polarity shaping applied to every captured sample.
  function automatic logic [GS_BITS-1:0] shape_sample(input logic [GS_BITS-1:0] p);
`ifdef CAM_SAMPLE_INVERT_EN
    return {GS_BITS{1'b1}} - p;
`else
    return p;
`endif
  endfunction

endpackage

// File: rtl/sample_axis_counter.sv
// One raster axis: position counter plus in-window phase tracking, reporting the
// combinational wrap of the current position and whether it is a sample point.
module sample_axis_counter #(
  parameter int unsigned LEN    = 640,
  parameter int unsigned ORIGIN = 80,
  parameter int unsigned STEP   = 16,
  parameter int unsigned DIM    = 30
) (
  input  logic clk,
  input  logic rst,
  input  logic step,
  input  logic restart,
  output logic wrap_c,
  output logic hit_c
);

  localparam int unsigned PW       = $clog2(LEN + 1);
  localparam int unsigned PHW      = $clog2(STEP + 1);
  localparam int unsigned WIN_END  = ORIGIN + DIM * STEP;
  localparam int unsigned HALF     = STEP / 2;
  localparam bit          WIN_AT_0 = (ORIGIN == 0);

  logic [PW-1:0]  pos_q, pos_c, pos_n;
  logic [PHW-1:0] ph_q, ph_c, ph_n;
  logic           win_q, win_c, win_n;

  // restart forces the current element to be position 0 of a new pass
  always_comb begin
    pos_c  = restart ? '0 : pos_q;
    ph_c   = restart ? '0 : ph_q;
    win_c  = restart ? WIN_AT_0 : win_q;
    wrap_c = step && (pos_c == PW'(LEN - 1));
    hit_c  = win_c && (ph_c == PHW'(HALF));
    pos_n  = pos_c;
    ph_n   = ph_c;
    win_n  = win_c;
    if (step) begin
      if (wrap_c) begin
        pos_n = '0;
        ph_n  = '0;
        win_n = WIN_AT_0;
      end else begin
        pos_n = pos_c + PW'(1);
        ph_n  = (!win_c || ph_c == PHW'(STEP - 1)) ? '0 : ph_c + PHW'(1);
        win_n = (pos_n == PW'(ORIGIN)) || (win_c && pos_n != PW'(WIN_END));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pos_q <= '0;
      ph_q  <= '0;
      win_q <= WIN_AT_0;
    end else if (step || restart) begin
      pos_q <= pos_n;
      ph_q  <= ph_n;
      win_q <= win_n;
    end
  end

endmodule

// File: rtl/cam_frame_sampler.sv
// Crops a square window from a raster camera stream and centre-samples it down to
// IMG_DIM x IMG_DIM. Build macro CAM_SAMPLE_INVERT_EN inverts the sample polarity.
module cam_frame_sampler
  import cam_pkg::*;
#(
  parameter int unsigned CAM_W   = 640,
  parameter int unsigned CAM_H   = 480,
  parameter int unsigned IMG_DIM = 30,
  parameter int unsigned STEP    = 16,
  parameter int unsigned X0      = 80,
  parameter int unsigned Y0      = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [GS_BITS-1:0]   cam_pixel,
  input  logic                 cam_valid,
  input  logic                 cam_sof,
  input  logic                 dst_ready,
  output logic [GS_BITS-1:0]   raw_pixel,
  output logic                 raw_pixel_valid,
  output logic                 EOF,
  output logic                 frame_err,
  output logic [DROP_BITS-1:0] frames_dropped
);

  if (X0 + IMG_DIM * STEP > CAM_W) begin : g_bad_x
    $error("cam_frame_sampler: crop window exceeds CAM_W");
  end
  if (Y0 + IMG_DIM * STEP > CAM_H) begin : g_bad_y
    $error("cam_frame_sampler: crop window exceeds CAM_H");
  end

  samp_state_t        state_q, state_d, eff_state;
  logic               sof_ev, last_pix;
  logic               x_wrap, x_hit, y_wrap, y_hit;
  logic               valid_d, eof_d, err_d, drop_inc;
  logic [GS_BITS-1:0] pix_d;

  assign sof_ev   = cam_valid && cam_sof;
  assign last_pix = x_wrap && y_wrap;

  sample_axis_counter #(.LEN(CAM_W), .ORIGIN(X0), .STEP(STEP), .DIM(IMG_DIM)) u_x_axis (
    .clk    (clk),
    .rst    (rst),
    .step   (cam_valid),
    .restart(sof_ev),
    .wrap_c (x_wrap),
    .hit_c  (x_hit)
  );

  sample_axis_counter #(.LEN(CAM_H), .ORIGIN(Y0), .STEP(STEP), .DIM(IMG_DIM)) u_y_axis (
    .clk    (clk),
    .rst    (rst),
    .step   (x_wrap),
    .restart(sof_ev),
    .wrap_c (y_wrap),
    .hit_c  (y_hit)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // A SOF always opens a fresh frame from the current pixel, aborting any frame in flight
  always_comb begin
    state_d   = state_q;
    eff_state = state_q;
    valid_d   = 1'b0;
    eof_d     = 1'b0;
    err_d     = 1'b0;
    drop_inc  = 1'b0;
    pix_d     = raw_pixel;
    if (sof_ev) begin
      err_d     = (state_q != IDLE);
      eff_state = dst_ready ? CAPTURE : SKIP;
      drop_inc  = !dst_ready;
    end
    if (cam_valid) begin
      state_d = eff_state;
      if (eff_state == CAPTURE && x_hit && y_hit) begin
        valid_d = 1'b1;
        pix_d   = shape_sample(cam_pixel);
      end
      if (eff_state != IDLE && last_pix) begin
        state_d = IDLE;
        eof_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      raw_pixel       <= '0;
      raw_pixel_valid <= 1'b0;
      EOF             <= 1'b0;
      frame_err       <= 1'b0;
      frames_dropped  <= '0;
    end else begin
      raw_pixel       <= pix_d;
      raw_pixel_valid <= valid_d;
      EOF             <= eof_d;
      frame_err       <= err_d;
      if (drop_inc && frames_dropped != '1) frames_dropped <= frames_dropped + DROP_BITS'(1);
    end
  end

endmodule

// File: tb/tb_cam_frame_sampler.sv
// Bench for cam_frame_sampler on a reduced 40x30 camera, 3x3 output, step 8.
module tb_cam_frame_sampler;

  localparam int CW = 40;
  localparam int CH = 30;
  localparam int DIM = 3;
  localparam int ST = 8;
  localparam int XO = 8;
  localparam int YO = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  cam_pixel = '0;
  logic        cam_valid = 1'b0;
  logic        cam_sof = 1'b0;
  logic        dst_ready = 1'b0;
  logic [7:0]  raw_pixel;
  logic        raw_pixel_valid;
  logic        EOF;
  logic        frame_err;
  logic [15:0] frames_dropped;

  int tests = 0;
  int fails = 0;

  cam_frame_sampler #(
    .CAM_W(CW), .CAM_H(CH), .IMG_DIM(DIM), .STEP(ST), .X0(XO), .Y0(YO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cam_pixel      (cam_pixel),
    .cam_valid      (cam_valid),
    .cam_sof        (cam_sof),
    .dst_ready      (dst_ready),
    .raw_pixel      (raw_pixel),
    .raw_pixel_valid(raw_pixel_valid),
    .EOF            (EOF),
    .frame_err      (frame_err),
    .frames_dropped (frames_dropped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int shape(input int p);
`ifdef CAM_SAMPLE_INVERT_EN
    return 255 - p;
`else
    return p;
`endif
  endfunction

  // Model: frame position from arithmetic, sample rule straight from the modulo definition
  int  mx = 0, my = 0, mode = 0;  // mode 0 idle, 1 capturing, 2 skipping
  int  exp_pix = 0, exp_drop = 0;
  bit  exp_valid = 0, exp_eof = 0, exp_err = 0, chk_en = 0;

  function automatic bit selected(input int p, input int org);
    return p >= org && p < org + DIM * ST && ((p - org) % ST) == ST / 2;
  endfunction

  always @(posedge clk) begin
    exp_valid = 0;
    exp_eof   = 0;
    exp_err   = 0;
    if (rst) begin
      chk_en   = 1;
      mx       = 0;
      my       = 0;
      mode     = 0;
      exp_pix  = 0;
      exp_drop = 0;
    end else if (cam_valid) begin
      if (cam_sof) begin
        exp_err = (mode != 0);
        mx = 0;
        my = 0;
        mode = dst_ready ? 1 : 2;
        if (!dst_ready && exp_drop < 65535) exp_drop++;
      end
      if (mode == 1 && selected(mx, XO) && selected(my, YO)) begin
        exp_valid = 1;
        exp_pix   = shape(int'(cam_pixel));
      end
      if (mode != 0 && mx == CW - 1 && my == CH - 1) begin
        exp_eof = 1;
        mode    = 0;
      end
      mx++;
      if (mx == CW) begin
        mx = 0;
        my = (my + 1) % CH;
      end
    end
  end

  int out_q[$];
  int eof_cnt = 0, err_cnt = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("raw_pixel_valid", int'(raw_pixel_valid), int'(exp_valid));
      chk("raw_pixel", int'(raw_pixel), exp_pix);
      chk("EOF", int'(EOF), int'(exp_eof));
      chk("frame_err", int'(frame_err), int'(exp_err));
      chk("frames_dropped", int'(frames_dropped), exp_drop);
      if (raw_pixel_valid) out_q.push_back(int'(raw_pixel));
      if (EOF) eof_cnt++;
      if (frame_err) err_cnt++;
    end
  end

  function automatic int qget(input int idx);
    return (idx < out_q.size()) ? out_q[idx] : -1;
  endfunction

  // Drives one frame; stop_at truncates it, rst_at pulses reset on that pixel
  task automatic send_frame(input bit rdy, input bit gaps, input int stop_at, input int rst_at);
    for (int i = 0; i < CW * CH && i < stop_at; i++) begin
      if (gaps && i != 0) begin
        while ($urandom_range(0, 2) == 0) begin
          @(negedge clk);
          rst       = 1'b0;
          cam_valid = 1'b0;
          cam_sof   = 1'($urandom);
          cam_pixel = 8'($urandom);
        end
      end
      @(negedge clk);
      rst       = (i == rst_at);
      cam_valid = 1'b1;
      cam_sof   = (i == 0);
      cam_pixel = 8'((i % CW) + 3 * (i / CW));
      dst_ready = (i == 0) ? rdy : 1'($urandom);
    end
    @(negedge clk);
    rst       = 1'b0;
    cam_valid = 1'b0;
    cam_sof   = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cam_valid = 1'b0;
      cam_sof   = 1'b0;
    end
  endtask

  int e0, r0;

  initial begin
    idle(3);
    @(negedge clk);
    rst = 1'b0;
    chk("reset valid", int'(raw_pixel_valid), 0);
    chk("reset pixel", int'(raw_pixel), 0);
    chk("reset EOF", int'(EOF), 0);
    chk("reset dropped", int'(frames_dropped), 0);

    // Continuous captured frame
    out_q.delete(); e0 = eof_cnt;
    send_frame(1'b1, 1'b0, 1 << 30, -1);
    idle(2);
    chk("f1 count", out_q.size(), 9);
    chk("f1 first", qget(0), shape(33));
    chk("f1 second", qget(1), shape(41));
    chk("f1 last", qget(8), shape(97));
    chk("f1 eof", eof_cnt - e0, 1);

    // Dropped frame, then captured frame
    out_q.delete(); e0 = eof_cnt;
    send_frame(1'b0, 1'b0, 1 << 30, -1);
    idle(2);
    chk("drop count", out_q.size(), 0);
    chk("drop eof", eof_cnt - e0, 1);
    chk("drop counter", int'(frames_dropped), 1);
    out_q.delete();
    send_frame(1'b1, 1'b0, 1 << 30, -1);
    idle(2);
    chk("after drop count", out_q.size(), 9);

    // Random valid gaps
    out_q.delete();
    send_frame(1'b1, 1'b1, 1 << 30, -1);
    idle(2);
    chk("gaps count", out_q.size(), 9);
    chk("gaps first", qget(0), shape(33));
    chk("gaps last", qget(8), shape(97));

    // Frame aborted by early SOF at pixel 600: first sample row only, then a full frame
    out_q.delete(); e0 = eof_cnt; r0 = err_cnt;
    send_frame(1'b1, 1'b0, 600, -1);
    send_frame(1'b1, 1'b0, 1 << 30, -1);
    idle(2);
    chk("abort err", err_cnt - r0, 1);
    chk("abort eof", eof_cnt - e0, 1);
    chk("abort count", out_q.size(), 12);
    chk("abort restart first", qget(3), shape(33));

    // Reset in mid capture: rest of that frame ignored, next frame complete
    out_q.delete(); e0 = eof_cnt;
    send_frame(1'b1, 1'b0, 1 << 30, 400);
    chk("rst mid count", out_q.size(), 3);
    chk("rst mid dropped", int'(frames_dropped), 0);
    send_frame(1'b1, 1'b0, 1 << 30, -1);
    idle(2);
    chk("rst mid eof", eof_cnt - e0, 1);
    chk("rst total count", out_q.size(), 12);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
